// File: rtl/fa_1b.sv
// One-bit full adder cell built from gate primitives, with propagate/generate taps.
// Define FA_1B_REG_OUT_EN to build the registered sum_q/cout_q copies; otherwise they are tied to 0.
module fa_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum,
    input  logic clk,
    input  logic rst,
    output logic p,
    output logic g,
    output logic sum_q,
    output logic cout_q
);

    logic p_and_cin;

    // sum and cout reuse p/g so a lookahead tree and the ripple path share the same gates
    xor u_xor_p   (p,         a, b);
    and u_and_g   (g,         a, b);
    xor u_xor_sum (sum,       p, cin);
    and u_and_pc  (p_and_cin, p, cin);
    or  u_or_cout (cout,      g, p_and_cin);

`ifdef FA_1B_REG_OUT_EN
    logic sum_d;
    logic cout_d;

    always_comb begin
        sum_d  = sum;
        cout_d = cout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign sum_q          = 1'b0;
    assign cout_q         = 1'b0;
`endif

endmodule

// File: tb/tb_fa_1b.sv
// Randomised self-checking bench for fa_1b: arithmetic reference model, 16-cell ripple chain,
// registered-path checks that follow FA_1B_REG_OUT_EN.
module tb_fa_1b;

    logic clk = 1'b0;
    logic rst;
    logic a, b, cin;
    logic cout, sum, p, g, sum_q, cout_q;

    int n_checks   = 0;
    int n_failures = 0;

    always #5 clk = ~clk;

    fa_1b u_dut (
        .a      (a),
        .b      (b),
        .cin    (cin),
        .cout   (cout),
        .sum    (sum),
        .clk    (clk),
        .rst    (rst),
        .p      (p),
        .g      (g),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    logic [15:0] ch_a, ch_b;
    logic        ch_cin;
    logic [16:0] ch_c;
    logic [15:0] ch_s, ch_p, ch_g;
    logic [15:0] ch_unused_sq, ch_unused_cq;

    assign ch_c[0] = ch_cin;

    for (genvar i = 0; i < 16; i++) begin : g_chain
        fa_1b u_cell (
            .a      (ch_a[i]),
            .b      (ch_b[i]),
            .cin    (ch_c[i]),
            .cout   (ch_c[i+1]),
            .sum    (ch_s[i]),
            .clk    (clk),
            .rst    (rst),
            .p      (ch_p[i]),
            .g      (ch_g[i]),
            .sum_q  (ch_unused_sq[i]),
            .cout_q (ch_unused_cq[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic sum of the three bits
    function automatic logic [1:0] ref_add(input logic ra, input logic rb, input logic rc);
        int t;
        t = int'(ra) + int'(rb) + int'(rc);
        return 2'(t);
    endfunction

    logic [1:0] exp_q;   // {cout_q, sum_q} expected after the next edge

    task automatic check_comb(input string tag);
        logic [1:0] r;
        r = ref_add(a, b, cin);
        check({tag, ".sum"},  {31'd0, sum},  {31'd0, r[0]});
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, r[1]});
        check({tag, ".p"},    {31'd0, p},    {31'd0, a ^ b});
        check({tag, ".g"},    {31'd0, g},    {31'd0, a & b});
    endtask

    // Drive on the falling edge, then cross one rising edge and check the registers
    task automatic step(input logic na, input logic nb, input logic nc, input logic nr, input string tag);
        @(negedge clk);
        a = na; b = nb; cin = nc; rst = nr;
        #1;
        check_comb(tag);
`ifdef FA_1B_REG_OUT_EN
        exp_q = nr ? 2'b00 : ref_add(na, nb, nc);
`else
        exp_q = 2'b00;
`endif
        @(posedge clk);
        #1;
        check({tag, ".sum_q"},  {31'd0, sum_q},  {31'd0, exp_q[0]});
        check({tag, ".cout_q"}, {31'd0, cout_q}, {31'd0, exp_q[1]});
    endtask

    task automatic chain_check(input logic [15:0] va, input logic [15:0] vb, input logic vc, input string tag);
        logic [16:0] tot;
        ch_a = va; ch_b = vb; ch_cin = vc;
        #1;
        tot = {1'b0, va} + {1'b0, vb} + {16'd0, vc};
        check({tag, ".sum"},   {16'd0, ch_s},           {16'd0, tot[15:0]});
        check({tag, ".carry"}, {31'd0, ch_c[16]},       {31'd0, tot[16]});
        check({tag, ".pg"},    {ch_p, ch_g},            {va ^ vb, va & vb});
    endtask

    initial begin
        a = 1'b0; b = 1'b0; cin = 1'b0; rst = 1'b1;
        ch_a = '0; ch_b = '0; ch_cin = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check("reset.sum_q",  {31'd0, sum_q},  32'd0);
        check("reset.cout_q", {31'd0, cout_q}, 32'd0);

        // Exhaustive sweep, still in reset
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            step(bits[2], bits[1], bits[0], 1'b1, $sformatf("sweep%0d", v));
        end

        // Release reset: a=1,b=0,cin=1 -> sum_q=0, cout_q=1 when registered
        step(1'b1, 1'b0, 1'b1, 1'b0, "release");

        // Reset mid-stream: latch 111 then reset for one edge
        step(1'b1, 1'b1, 1'b1, 1'b0, "latch111");
        step(1'b1, 1'b1, 1'b1, 1'b1, "midrst");
        step(1'b1, 1'b1, 1'b1, 1'b0, "afterrst");

        // Random stream with occasional reset
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
        end

        // Ripple chain
        chain_check(16'hFFFF, 16'h0001, 1'b0, "chain_ffff");
        chain_check(16'h1234, 16'h4321, 1'b1, "chain_1234");
        for (int i = 0; i < 30; i++) begin
            chain_check(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("chain_rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
